// File: rtl/mix_column_seq.sv
// Mini-AES MixColumn stage: mixes the 2x2 nibble state one column per clock over GF(2^4)
// with matrix [[3,2],[2,3]], behind a valid/ready handshake on both sides.
module mix_column_seq #(
    parameter logic [3:0] RED_POLY  = 4'h3,
    parameter bit         BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_last_round,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic        flag_q, flag_d;
    logic [15:0] result_q, result_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  col0_s;
    logic [7:0]  col1_s;

    function automatic logic [3:0] xtime(input logic [3:0] x);
        logic [3:0] r;
        r = {x[2:0], 1'b0};
        if (x[3]) begin
            r = r ^ RED_POLY;
        end
        return r;
    endfunction

    function automatic logic [7:0] mix_col(input logic [7:0] col);
        logic [3:0] p;
        logic [3:0] q;
        p = col[7:4];
        q = col[3:0];
        return {xtime(p) ^ p ^ xtime(q), xtime(p) ^ xtime(q) ^ q};
    endfunction

    // Column datapath; the last round copies nibbles through with identical timing
    always_comb begin
        col0_s = word_q[15:8];
        col1_s = word_q[7:0];
        if (flag_q && BYPASS_EN) begin
            col0_s = word_q[15:8];
            col1_s = word_q[7:0];
        end else begin
            col0_s = mix_col(word_q[15:8]);
            col1_s = mix_col(word_q[7:0]);
        end
    end

    // Ready is state-derived; the only combinational input term is out_ready
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        flag_d      = flag_q;
        result_d    = result_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    flag_d  = in_last_round;
                    state_d = COL0;
                end else begin
                    state_d = IDLE;
                end
            end
            COL0: begin
                result_d[15:8] = col0_s;
                state_d        = COL1;
            end
            COL1: begin
                result_d[7:0] = col1_s;
                out_data_d    = {result_q[15:8], col1_s};
                out_valid_d   = 1'b1;
                state_d       = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // Drain and accept in the same cycle keeps the 3-cycle cadence
                    if (in_valid) begin
                        word_d  = in_data;
                        flag_d  = in_last_round;
                        state_d = COL0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= 16'h0000;
            flag_q      <= 1'b0;
            result_q    <= 16'h0000;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            flag_q      <= flag_d;
            result_q    <= result_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mix_column_seq.sv
// Self-checking bench for mix_column_seq: two instances (bypass enabled / disabled) driven in
// lockstep, checked against a generic GF(2^4) multiply model, directed tables and random streams.
module tb_mix_column_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_last_round;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, in_ready_b;
    logic [15:0] out_data, out_data_b;
    logic        out_valid, out_valid_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_column_seq #(.RED_POLY(4'h3), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last_round(in_last_round),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mix_column_seq #(.RED_POLY(4'h3), .BYPASS_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last_round(in_last_round),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    // Polynomial multiply then reduce modulo x^4+x+1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ (8'(a) << i);
        end
        for (int k = 6; k >= 4; k--) begin
            if (r[k]) r = r ^ (8'h13 << (k - 4));
        end
        return r[3:0];
    endfunction

    function automatic logic [15:0] ref_mix(input logic [15:0] w, input logic last, input logic byp);
        logic [3:0] n[4];
        logic [3:0] o[4];
        if (last && byp) return w;
        for (int i = 0; i < 4; i++) n[i] = w[15 - 4*i -: 4];
        for (int c = 0; c < 2; c++) begin
            o[2*c]     = gf_mul(4'h3, n[2*c]) ^ gf_mul(4'h2, n[2*c+1]);
            o[2*c + 1] = gf_mul(4'h2, n[2*c]) ^ gf_mul(4'h3, n[2*c+1]);
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("wait_in_ready", 16'(in_ready), 16'h0001);
    endtask

    // Accept one word now, return cycles until out_valid (accept edge counts as 1)
    task automatic send_and_wait(input logic [15:0] d, input logic last, output int lat);
        in_data       = d;
        in_last_round = last;
        in_valid      = 1'b1;
        lat = 0;
        do begin
            tick();
            in_valid = 1'b0;
            in_data  = 16'hFFFF;
            lat++;
        end while (!out_valid && lat < 10);
    endtask

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [15:0] exp_byp;
        logic [15:0] exp_nobyp;
    } vec_t;

    typedef struct {
        logic [15:0] e1;
        logic [15:0] e0;
    } exp_t;

    vec_t vecs[7];
    exp_t q[$];

    initial begin
        int lat;
        logic [15:0] held;
        int sent, rcvd, cyc;
        exp_t e;

        vecs[0] = '{16'h1000, 1'b0, 16'h3200, 16'h3200};
        vecs[1] = '{16'h8000, 1'b0, 16'hB300, 16'hB300};
        vecs[2] = '{16'h1023, 1'b0, 16'h3201, 16'h3201};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{16'hABCD, 1'b1, 16'hABCD, 16'h89EF};
        vecs[5] = '{16'h1000, 1'b1, 16'h1000, 16'h3200};
        vecs[6] = '{16'hABCD, 1'b0, 16'h89EF, 16'h89EF};

        rst = 1'b1; in_data = 16'h0000; in_last_round = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", 16'(out_valid), 16'h0000);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_in_ready", 16'(in_ready), 16'h0001);

        // Directed table
        foreach (vecs[i]) begin
            wait_ready();
            send_and_wait(vecs[i].data, vecs[i].last, lat);
            check("vec_latency", 16'(lat), 16'd3);
            check("vec_data_byp", out_data, vecs[i].exp_byp);
            check("vec_data_nobyp", out_data_b, vecs[i].exp_nobyp);
            check("vec_model", vecs[i].exp_nobyp, ref_mix(vecs[i].data, vecs[i].last, 1'b0));
            tick();
            check("vec_drained", 16'(out_valid), 16'h0000);
        end

        // Backpressure with a competing word that must be ignored
        wait_ready();
        out_ready = 1'b0;
        send_and_wait(16'h8000, 1'b0, lat);
        held = out_data;
        check("bp_first", held, 16'hB300);
        in_valid = 1'b1; in_data = 16'h1234; in_last_round = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", 16'(in_ready), 16'h0000);
            check("bp_stable", out_data, held);
            check("bp_valid", 16'(out_valid), 16'h0001);
            tick();
        end
        out_ready = 1'b1;
        in_data = 16'h1023; in_last_round = 1'b0;
        #1;
        check("bp_ready_comb", 16'(in_ready), 16'h0001);
        lat = 0;
        do begin
            tick();
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        check("bp_next_latency", 16'(lat), 16'd3);
        check("bp_next_data", out_data, 16'h3201);
        tick();

        // Reset mid-COL1 discards the word in flight
        wait_ready();
        in_data = 16'h1000; in_last_round = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("mid_rst_valid", 16'(out_valid), 16'h0000);
        check("mid_rst_data", out_data, 16'h0000);
        check("mid_rst_ready", 16'(in_ready), 16'h0001);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) lat++;
            tick();
        end
        check("mid_rst_no_output", 16'(lat), 16'h0000);

        // Random stream against the reference model
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 50 && cyc < 4000) begin
            in_valid      = (sent < 50) && ($urandom_range(0, 3) != 0);
            in_data       = 16'($urandom);
            in_last_round = ($urandom_range(0, 3) == 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                e.e1 = ref_mix(in_data, in_last_round, 1'b1);
                e.e0 = ref_mix(in_data, in_last_round, 1'b0);
                q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_spurious", 16'h0001, 16'h0000);
                end else begin
                    e = q.pop_front();
                    check("stream_byp", out_data, e.e1);
                    check("stream_nobyp", out_data_b, e.e0);
                end
                rcvd++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_rcvd", 16'(rcvd), 16'd50);
        check("stream_sent", 16'(sent), 16'd50);
        check("stream_queue_empty", 16'(q.size()), 16'h0000);
        tick(); tick(); tick(); tick();
        check("stream_no_extra", 16'(out_valid), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
